// File: rtl/crg_pkg.sv
// Shared encodings for the clock/reset generator: sequencer FSM states and
// the reason the last reset sequence was started.
package crg_pkg;

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } crg_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_TRIG = 2'd1,
    CAUSE_LOCK = 2'd2
  } crg_cause_e;

endpackage

// File: rtl/crg_sync.sv
// Multi-flop synchroniser for one asynchronous level signal, cleared by the
// asynchronous active-low reset.
module crg_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/crg_reset_sequencer.sv
// Reset sequencer: holds all resets after POR/trigger/lock loss, qualifies
// the PLL/DCM locks, then releases each reset channel at its own delay.
module crg_reset_sequencer
  import crg_pkg::*;
#(
  parameter int                        N_CHAN      = 3,
  parameter int                        N_LOCK      = 2,
  parameter int                        HOLD_W      = 20,
  parameter logic [HOLD_W-1:0]         HOLD_CYCLES = 20'hFFFFF,
  parameter int                        SYNC_STAGES = 2,
  parameter int                        LOCK_FILTER = 16,
  parameter int                        DELAY_W     = 8,
  parameter logic [N_CHAN*DELAY_W-1:0] CHAN_DELAY  = {8'd0, 8'd128, 8'd200}
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              trigger_reset,
  input  logic [N_LOCK-1:0] locked,
  output logic [N_CHAN-1:0] rst_out,
  output logic              busy,
  output logic [1:0]        state,
  output logic [1:0]        reset_cause
);

  function automatic logic [DELAY_W-1:0] max_delay(input logic [N_CHAN*DELAY_W-1:0] d);
    logic [DELAY_W-1:0] m;
    m = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (d[i*DELAY_W +: DELAY_W] > m) m = d[i*DELAY_W +: DELAY_W];
    end
    return m;
  endfunction

  localparam logic [DELAY_W-1:0] MAX_DELAY = max_delay(CHAN_DELAY);
  localparam int                 FILT_W    = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam logic [FILT_W-1:0]  FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_CYCLES - 1'b1;

  logic [N_LOCK-1:0] lock_s;
  logic              lock_ok;

  for (genvar g = 0; g < N_LOCK; g++) begin : g_lock_sync
    crg_sync #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i (sys_clk),
      .rst_ni(sys_rst_n),
      .d_i   (locked[g]),
      .q_o   (lock_s[g])
    );
  end

  assign lock_ok = &lock_s;

  crg_state_e         state_q;
  crg_cause_e         cause_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [FILT_W-1:0]  filt_cnt_q;
  logic [DELAY_W-1:0] rel_cnt_q;
  logic [N_CHAN-1:0]  rst_q;
  logic               busy_q;

  // Lock loss while still waiting for lock only restarts the filter; in HOLD
  // nothing can abort, the hold is merely stretched by the trigger.
  logic       abort_d;
  crg_cause_e abort_cause_d;

  assign abort_d       = (state_q != ST_HOLD) &&
                         (trigger_reset || ((state_q != ST_WAIT_LOCK) && !lock_ok));
  assign abort_cause_d = trigger_reset ? CAUSE_TRIG : CAUSE_LOCK;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_HOLD;
      cause_q    <= CAUSE_POR;
      hold_cnt_q <= '0;
      filt_cnt_q <= '0;
      rel_cnt_q  <= '0;
      rst_q      <= '1;
      busy_q     <= 1'b1;
    end else if (abort_d) begin
      state_q    <= ST_HOLD;
      cause_q    <= abort_cause_d;
      hold_cnt_q <= '0;
      filt_cnt_q <= '0;
      rel_cnt_q  <= '0;
      rst_q      <= '1;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (trigger_reset) begin
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q    <= ST_WAIT_LOCK;
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (!lock_ok) begin
            filt_cnt_q <= '0;
          end else if (filt_cnt_q == FILT_LAST) begin
            state_q    <= ST_RELEASE;
            filt_cnt_q <= '0;
            rel_cnt_q  <= '0;
          end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          // Cleared channels stay cleared: only the abort path sets them again.
          for (int i = 0; i < N_CHAN; i++) begin
            if (rel_cnt_q == CHAN_DELAY[i*DELAY_W +: DELAY_W]) rst_q[i] <= 1'b0;
          end
          if (rel_cnt_q == MAX_DELAY) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end else begin
            rel_cnt_q <= rel_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
        end
        default: begin
          state_q <= ST_HOLD;
          rst_q   <= '1;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign rst_out     = rst_q;
  assign busy        = busy_q;
  assign state       = state_q;
  assign reset_cause = cause_q;

endmodule

// File: tb/tb_crg_reset_sequencer.sv
// Scoreboard bench for crg_reset_sequencer: a phase/elapsed-time reference
// model queues the expected outputs, a monitor compares them after each event.
module tb_crg_reset_sequencer;

  localparam int          N_CHAN      = 3;
  localparam int          N_LOCK      = 2;
  localparam int          HOLD_W      = 20;
  localparam int          HOLD_CYC    = 16;
  localparam int          LOCK_FILTER = 4;
  localparam int          DELAY_W     = 8;
  // Channel i occupies bits [i*8 +: 8]: chan0=0, chan1=5, chan2=12.
  localparam logic [23:0] DELAYS      = {8'd12, 8'd5, 8'd0};

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              trigger_reset = 1'b0;
  logic [N_LOCK-1:0] locked = 2'b11;
  logic [N_CHAN-1:0] rst_out;
  logic              busy;
  logic [1:0]        state;
  logic [1:0]        reset_cause;

  int checks = 0;
  int failures = 0;

  crg_reset_sequencer #(
    .N_CHAN     (N_CHAN),
    .N_LOCK     (N_LOCK),
    .HOLD_W     (HOLD_W),
    .HOLD_CYCLES(20'(HOLD_CYC)),
    .SYNC_STAGES(2),
    .LOCK_FILTER(LOCK_FILTER),
    .DELAY_W    (DELAY_W),
    .CHAN_DELAY (DELAYS)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .trigger_reset(trigger_reset),
    .locked       (locked),
    .rst_out      (rst_out),
    .busy         (busy),
    .state        (state),
    .reset_cause  (reset_cause)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [2:0] rst;
    logic [1:0] st;
    logic       bsy;
    logic [1:0] cause;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: phase 0..3 = HOLD, WAIT_LOCK, RELEASE, RUN.
  int   m_phase, m_t, m_good, m_cause, m_max;
  int   dly[N_CHAN];
  bit   h1, h2;

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < N_CHAN; i++) begin
      if (m_phase == 3)      e.rst[i] = 1'b0;
      else if (m_phase == 2) e.rst[i] = (m_t <= dly[i]);
      else                   e.rst[i] = 1'b1;
    end
    e.st    = 2'(m_phase);
    e.bsy   = (m_phase != 3);
    e.cause = 2'(m_cause);
    return e;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_t = 0; m_good = 0; m_cause = 0; h1 = 0; h2 = 0;
  endfunction

  function automatic void model_abort(input bit trig);
    m_phase = 0; m_t = 0; m_good = 0;
    m_cause = trig ? 1 : 2;
  endfunction

  function automatic void model_step(input bit trig, input bit lk_now);
    bit lk;
    lk = h2;
    h2 = h1;
    h1 = lk_now;
    case (m_phase)
      0: begin
        if (trig) m_t = 0;
        else begin
          m_t++;
          if (m_t == HOLD_CYC) begin m_phase = 1; m_good = 0; end
        end
      end
      1: begin
        if (trig) model_abort(trig);
        else begin
          m_good = lk ? m_good + 1 : 0;
          if (m_good == LOCK_FILTER) begin m_phase = 2; m_t = 0; end
        end
      end
      2: begin
        if (trig || !lk) model_abort(trig);
        else begin
          m_t++;
          if (m_t > m_max) m_phase = 3;
        end
      end
      default: if (trig || !lk) model_abort(trig);
    endcase
  endfunction

  initial begin
    logic [23:0] dv;
    dv = DELAYS;
    m_max = 0;
    for (int i = 0; i < N_CHAN; i++) begin
      dly[i] = int'(dv[i*8 +: 8]);
      if (dly[i] > m_max) m_max = dly[i];
    end
    model_reset();
    @(negedge sys_clk);
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) model_reset();
      else model_step(trigger_reset, &locked);
      exp_q.push_back(model_out());
    end
  end

  // Monitor
  initial begin
    exp_t e, a;
    @(negedge sys_clk);
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      #1;
      checks++;
      a = {rst_out, state, busy, reset_cause};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty at %0t: no expected entry for rst=%b state=%0d", $time, rst_out, state);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL outputs at %0t: got rst=%b state=%0d busy=%b cause=%0d, want rst=%b state=%0d busy=%b cause=%0d",
                   $time, a.rst, a.st, a.bsy, a.cause, e.rst, e.st, e.bsy, e.cause);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (state !== s) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: state=%0d, wanted %0d within %0d cycles", name, state, s, budget);
    end
  endtask

  initial begin
    // POR with locks steady, full release sequence.
    cyc(3);
    sys_rst_n = 1'b1;
    cyc(50);
    wait_state(2'd3, 20, "por_run");
    // One-cycle trigger in RUN, then the sequence repeats.
    trigger_reset = 1'b1;
    cyc(1);
    trigger_reset = 1'b0;
    cyc(45);
    wait_state(2'd3, 20, "trig_run");
    // Lock loss during RELEASE with chan0 released, chan1 still held.
    trigger_reset = 1'b1;
    cyc(1);
    trigger_reset = 1'b0;
    wait_state(2'd2, 60, "rel_enter");
    cyc(2);
    locked[1] = 1'b0;
    cyc(3);
    locked[1] = 1'b1;
    // Lock chatter in WAIT_LOCK keeps the filter from completing.
    wait_state(2'd1, 60, "wait_enter");
    for (int i = 0; i < 30; i++) begin
      locked[0] = (i % 3 != 0);
      cyc(1);
    end
    locked[0] = 1'b1;
    cyc(30);
    wait_state(2'd3, 30, "chatter_run");
    // Long trigger held through HOLD stretches the hold.
    trigger_reset = 1'b1;
    cyc(40);
    trigger_reset = 1'b0;
    cyc(40);
    wait_state(2'd3, 30, "long_trig_run");
    // Trigger and lock loss reach the FSM on the same edge.
    locked[1] = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    trigger_reset = 1'b1;
    cyc(1);
    trigger_reset = 1'b0;
    locked[1] = 1'b1;
    // Async POR in the middle of RELEASE.
    wait_state(2'd2, 60, "rel_enter2");
    cyc(3);
    sys_rst_n = 1'b0;
    cyc(2);
    sys_rst_n = 1'b1;
    cyc(50);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      trigger_reset = ($urandom_range(0, 99) == 0);
      for (int b = 0; b < N_LOCK; b++) locked[b] = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 799) == 0) begin
        sys_rst_n = 1'b0;
        cyc($urandom_range(1, 3));
        sys_rst_n = 1'b1;
      end
      cyc(1);
    end
    trigger_reset = 1'b0;
    locked = 2'b11;
    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
